sprite_units: RTL
=================

# sprite_units

Eight-slot sprite output stage downstream of the sprite-evaluation OAM block. During the fetch window (cycles 257–320) it captures each secondary-OAM sprite's attribute, X and sprite-0 flag from the OAM block, plus the two pattern bytes returned by pattern memory. During visible cycles 1–256 of the next scanline it counts down X, shifts out pattern bits and resolves the frontmost opaque sprite pixel. It feeds the background/sprite priority mux and sprite-0-hit logic.

## Interface
- No parameters.
- clk  in  1  PPU clock
- rst_n  in  1  asynchronous active-low reset
- rend  in  1  rendering enabled; gates loading and shifting
- cycle  in  9  current PPU cycle (0–340)
- ppumask  in  8  bit4 = show sprites, bit2 = show sprites in leftmost 8 pixels
- attribute  in  8  sprite attribute from OAM block (bit7 vflip already applied upstream, bit6 hflip, bit5 priority, bits1:0 palette)
- x  in  8  sprite X from OAM block
- sp0  in  1  current fetched sprite is sprite 0
- sp_valid  in  1  current secondary-OAM slot holds a real sprite (0 for $FF filler)
- pat_din  in  8  pattern byte from pattern memory (1-cycle read latency)
- sp_pix  out  2  resolved sprite pixel, 0 = transparent
- sp_pal  out  2  palette of resolved pixel
- sp_pri  out  1  priority bit (1 = behind background)
- sp_zero  out  1  resolved opaque pixel came from a slot holding sprite 0

## Operation
- Per slot k (0–7): pat_lo[7:0], pat_hi[7:0], pal[1:0], pri, is_sp0, xcnt[7:0].
- Fetch window (rend=1, cycles 257–320), slot base b = 257+8k:
  - at b+5 (cycle[2:0]==6): sample attribute, x, sp0, sp_valid; sample pat_din as lo byte into staging registers.
  - at b+7 (cycle[2:0]==0): sample pat_din as hi byte; commit the staging registers to slot k.
  - k = (cycle−257)>>3 at sampling time; commit at 264+8k writes slot k (last commit at cycle 320).
- Commit rules: if attribute[6] is set, reverse the bit order of both pattern bytes. If sp_valid=0, write both bytes as 0 (transparent), xcnt=FF, is_sp0=0.
- Render (rend=1, cycles 1–256, screen px = cycle−1), per slot:
  - xcnt≠0: xcnt−1, shifter held.
  - xcnt==0: emit {pat_hi[7], pat_lo[7]}, then shift both bytes left with 0 fill.
  - Each slot becomes transparent after 8 shifts.
- Priority: the lowest-index slot with a nonzero pixel wins. Its pal/pri/is_sp0 drive the outputs.
- Masking, applied before output (outputs forced to 0):
  - ppumask[4]=0, or
  - ppumask[2]=0 and px<8.
- Outside cycles 1–256, or when rend=0: nothing shifts or counts; outputs are 0. Slot contents are held.
- rend dropping mid-fetch: pending staging is discarded; already-committed slots are kept.

## Timing
- Reset (async assert, sync deassert by top level):
  - all pattern bytes 0; xcnt FF; pal/pri/is_sp0 0.
  - sp_pix, sp_pal, sp_pri, sp_zero = 0.
- Latency: outputs are registered. Pixel for screen px appears in cycle px+2 (the cycle after its render cycle px+1) and holds one cycle.
- Sprite with X=n: first pixel at screen px=n, last at n+7. X≥249 is clipped at px 255; no wrap to the next line.
- Simultaneous commit and render cannot occur (disjoint windows). Slot updates take effect for the following scanline only.
- cycle 0 and cycles 321–340: idle; state held.

## Test plan
- Slot 0: attr=0x01, x=10, pat lo=0xF0, hi=0x0F, sp_valid=1 -> px 10–13 sp_pix=1, px 14–17 sp_pix=2, sp_pal=1. Each pixel appears at cycle px+2; all other px 0.
- Slot 2 hflip: attr=0x40, lo=0x80 -> at px=x+7, sp_pix=1, all other pixels 0. Slot 2 with sp_valid=0 and lo=0xFF -> never opaque.
- Overlap: slot1 (pal 2) and slot3 (pal 3) both at x=20, both opaque -> sp_pal=2. Slot1 transparent bits -> slot3 shows through.
- sp0 at slot0, x=0, ppumask=0x10 (bit2 clear) -> px 0–7 output 0, sp_zero=0. With ppumask=0x14 -> sp_zero=1 on opaque px 0–7.
- x=252, pattern 0xFF -> opaque px 252–255 only. No output during cycles 257–340 or at the start of the next line before reload.
- rst_n pulsed low at cycle 130 mid-sprite -> outputs 0 immediately (async); no sprite pixels appear until the next fetch window commits.

Source files
------------

// File: rtl/sprite_units.sv
// sprite_units: eight-slot sprite output stage. Captures secondary-OAM sprites
// during the fetch window, then counts down X, shifts pattern bits and
// resolves the frontmost opaque sprite pixel during the visible cycles.
module sprite_units (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rend,
    input  logic [8:0] cycle,
    input  logic [7:0] ppumask,
    input  logic [7:0] attribute,
    input  logic [7:0] x,
    input  logic       sp0,
    input  logic       sp_valid,
    input  logic [7:0] pat_din,
    output logic [1:0] sp_pix,
    output logic [1:0] sp_pal,
    output logic       sp_pri,
    output logic       sp_zero
);

    // Per-slot state
    logic [7:0] r_pat_lo [8];
    logic [7:0] r_pat_hi [8];
    logic [1:0] r_pal    [8];
    logic       r_pri    [8];
    logic       r_is_sp0 [8];
    logic [7:0] r_xcnt   [8];

    // Staging registers filled at the lo-byte phase of each slot fetch
    logic       r_stg_vld;
    logic [7:0] r_stg_attr;
    logic [7:0] r_stg_x;
    logic [7:0] r_stg_lo;
    logic       r_stg_sp0;
    logic       r_stg_valid;

    // Registered outputs
    logic [1:0] r_sp_pix;
    logic [1:0] r_sp_pal;
    logic       r_sp_pri;
    logic       r_sp_zero;

    logic       w_fetch;
    logic       w_render;
    logic       w_sample;
    logic       w_commit;
    logic [8:0] w_off;
    logic [2:0] w_slot;
    logic [7:0] w_c_lo;
    logic [7:0] w_c_hi;
    logic [7:0] w_c_x;
    logic [1:0] w_c_pal;
    logic       w_c_pri;
    logic       w_c_sp0;
    logic [1:0] w_pix [8];
    logic [1:0] w_res_pix;
    logic [1:0] w_res_pal;
    logic       w_res_pri;
    logic       w_res_zero;
    logic       w_show;
    logic       w_unused;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    assign w_fetch  = rend && (cycle >= 9'd257) && (cycle <= 9'd320);
    assign w_render = rend && (cycle >= 9'd1) && (cycle <= 9'd256);
    assign w_sample = w_fetch && (cycle[2:0] == 3'd6);
    // Commit only when the matching lo-byte phase was seen with rendering on
    assign w_commit = w_fetch && (cycle[2:0] == 3'd0) && r_stg_vld;
    assign w_off    = cycle - 9'd257;
    assign w_slot   = w_off[5:3];
    // Leftmost-8 clip: px < 8 corresponds to cycles 1..8
    assign w_show   = w_render && ppumask[4] && (ppumask[2] || (cycle > 9'd8));
    assign w_unused = ^{attribute[7], attribute[4:2], w_off[8:6], w_off[2:0],
                        ppumask[7:5], ppumask[3], ppumask[1:0]};

    // Stage attribute/X/flags and lo byte; drop staging whenever rendering stops
    // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_vld   <= 1'b0;
            r_stg_attr  <= '0;
            r_stg_x     <= '0;
            r_stg_lo    <= '0;
            r_stg_sp0   <= 1'b0;
            r_stg_valid <= 1'b0;
        end else if (!rend) begin
            r_stg_vld <= 1'b0;
        end else if (w_sample) begin
            r_stg_vld   <= 1'b1;
            r_stg_attr  <= attribute;
            r_stg_x     <= x;
            r_stg_lo    <= pat_din;
            r_stg_sp0   <= sp0;
            r_stg_valid <= sp_valid;
        end else if (w_fetch && (cycle[2:0] == 3'd0)) begin
            r_stg_vld <= 1'b0;
        end
    end

    // Build the slot image to commit: hflip reversal, filler slots forced transparent
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_c_lo  = r_stg_attr[6] ? rev8(r_stg_lo) : r_stg_lo;
        w_c_hi  = r_stg_attr[6] ? rev8(pat_din) : pat_din;
        w_c_x   = r_stg_x;
        w_c_pal = r_stg_attr[1:0];
        w_c_pri = r_stg_attr[5];
        w_c_sp0 = r_stg_sp0;
        if (!r_stg_valid) begin
            w_c_lo  = '0;
            w_c_hi  = '0;
            w_c_x   = 8'hFF;
            w_c_pal = '0;
            w_c_pri = 1'b0;
            w_c_sp0 = 1'b0;
        end
    end

    // Slot registers: commit in the fetch window, count down / shift while rendering
    // NOTE: the slot array is small control state that must start transparent, so it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                r_pat_lo[k] <= '0;
                r_pat_hi[k] <= '0;
                r_pal[k]    <= '0;
                r_pri[k]    <= 1'b0;
                r_is_sp0[k] <= 1'b0;
                r_xcnt[k]   <= 8'hFF;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_commit && (w_slot == 3'(k))) begin
                    r_pat_lo[k] <= w_c_lo;
                    r_pat_hi[k] <= w_c_hi;
                    r_pal[k]    <= w_c_pal;
                    r_pri[k]    <= w_c_pri;
                    r_is_sp0[k] <= w_c_sp0;
                    r_xcnt[k]   <= w_c_x;
                end else if (w_render) begin
                    if (r_xcnt[k] != 8'd0) begin
                        r_xcnt[k] <= r_xcnt[k] - 8'd1;
                    end else begin
                        r_pat_lo[k] <= {r_pat_lo[k][6:0], 1'b0};
                        r_pat_hi[k] <= {r_pat_hi[k][6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Current pixel of each slot (only once its X counter has expired)
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_pix[k] = (r_xcnt[k] == 8'd0) ? {r_pat_hi[k][7], r_pat_lo[k][7]} : 2'b00;
        end
    end

    // Priority resolve: scan high to low so the lowest opaque slot wins
    always_comb begin
        w_res_pix  = '0;
        w_res_pal  = '0;
        w_res_pri  = 1'b0;
        w_res_zero = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (w_pix[k] != 2'b00) begin
                w_res_pix  = w_pix[k];
                w_res_pal  = r_pal[k];
                w_res_pri  = r_pri[k];
                w_res_zero = r_is_sp0[k];
            end
        end
    end

    // Output register with masking; zero outside visible rendering
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp_pix  <= '0;
            r_sp_pal  <= '0;
            r_sp_pri  <= 1'b0;
            r_sp_zero <= 1'b0;
        end else if (w_show) begin
            r_sp_pix  <= w_res_pix;
            r_sp_pal  <= w_res_pal;
            r_sp_pri  <= w_res_pri;
            r_sp_zero <= w_res_zero;
        end else begin
            r_sp_pix  <= '0;
            r_sp_pal  <= '0;
            r_sp_pri  <= 1'b0;
            r_sp_zero <= 1'b0;
        end
    end

    assign sp_pix  = r_sp_pix;
    assign sp_pal  = r_sp_pal;
    assign sp_pri  = r_sp_pri;
    assign sp_zero = r_sp_zero;

endmodule
